// File: rtl/ema_pulse_monitor.sv
// rtl/ema_pulse_monitor.sv - EMA pulse pair receive checker: P period, P high time, N edge count, loss of signal
module ema_pulse_monitor #(
    parameter int CNT_WIDTH      = 26,
    parameter int TIMEOUT_CYCLES = 2 ** 25,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 CLK_0,
    input  logic                 RST_N,
    input  logic                 PULSE_P_IN,
    input  logic                 PULSE_N_IN,
    output logic [CNT_WIDTH-1:0] PERIOD,
    output logic [CNT_WIDTH-1:0] HIGH_TIME,
    output logic [7:0]           N_EDGES,
    output logic                 MEAS_VALID,
    output logic                 NO_SIGNAL
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] p_sync, n_sync;
    logic                   p_hist, n_hist;
    logic                   p_rise, p_fall, n_rise;
    logic [CNT_WIDTH-1:0]   cnt, hi_lat;
    logic [7:0]             n_cnt;
    logic                   meas_fire, timeout;

    // Edges are a mismatch between the last synchronizer stage and one history flop.
    assign p_rise = p_sync[SYNC_STAGES-1] & ~p_hist;
    assign p_fall = ~p_sync[SYNC_STAGES-1] & p_hist;
    assign n_rise = n_sync[SYNC_STAGES-1] & ~n_hist;

    always_ff @(posedge CLK_0) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        meas_fire = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (p_rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                // A rising edge beats a coincident timeout.
                if (p_rise) begin
                    meas_fire = 1'b1;
                end else if (cnt == TIMEOUT_VAL) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_0) begin
        if (!RST_N) begin
            p_sync     <= '0;
            n_sync     <= '0;
            p_hist     <= 1'b0;
            n_hist     <= 1'b0;
            cnt        <= '0;
            hi_lat     <= '0;
            n_cnt      <= '0;
            PERIOD     <= '0;
            HIGH_TIME  <= '0;
            N_EDGES    <= '0;
            MEAS_VALID <= 1'b0;
            NO_SIGNAL  <= 1'b0;
        end else begin
            p_sync     <= {p_sync[SYNC_STAGES-2:0], PULSE_P_IN};
            n_sync     <= {n_sync[SYNC_STAGES-2:0], PULSE_N_IN};
            p_hist     <= p_sync[SYNC_STAGES-1];
            n_hist     <= n_sync[SYNC_STAGES-1];
            MEAS_VALID <= meas_fire;
            if (state_q == IDLE) begin
                hi_lat <= '0;
                n_cnt  <= '0;
                if (p_rise) begin
                    cnt       <= CNT_ONE;
                    NO_SIGNAL <= 1'b0;
                end else begin
                    cnt <= '0;
                end
            end else if (meas_fire) begin
                PERIOD    <= cnt;
                HIGH_TIME <= hi_lat;
                N_EDGES   <= n_cnt;
                cnt       <= CNT_ONE;
                hi_lat    <= '0;
                n_cnt     <= {7'd0, n_rise};
            end else if (timeout) begin
                NO_SIGNAL <= 1'b1;
                cnt       <= '0;
                hi_lat    <= '0;
                n_cnt     <= '0;
            end else begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end
                if (p_fall) begin
                    hi_lat <= cnt;
                end
                if (n_rise && n_cnt != 8'hFF) begin
                    n_cnt <= n_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/ema_pulse_monitor.md
# ema_pulse_monitor

Receive-side checker for the EMA pulse pair. The block samples the EMA_PULSE_P / EMA_PULSE_N signals, either looped back from the pins or taken from an external probe, on the 20 MHz CLK_0 domain. For every pulse period it measures the P-channel period, the P-channel high time, and the number of N-channel rising edges, then presents each result with a one-cycle valid strobe. It also flags loss of signal, so the board can self-test the pulse generator without a scope.

## Interface

Parameters:
- CNT_WIDTH, 26: width of the period/high-time counters; covers a 2^24-cycle period with margin.
- TIMEOUT_CYCLES, 2^25: cycles without a P rising edge before NO_SIGNAL asserts; must be less than 2^CNT_WIDTH − 1.
- SYNC_STAGES, 2: flip-flop synchronizer depth on each input (≥ 2).

Ports:
- CLK_0, in, 1: 20 MHz system clock; all logic on its rising edge.
- RST_N, in, 1: reset, synchronous to CLK_0, active-low.
- PULSE_P_IN, in, 1: asynchronous P-channel pulse input.
- PULSE_N_IN, in, 1: asynchronous N-channel pulse input.
- PERIOD, out, CNT_WIDTH: last measured P period in CLK_0 cycles.
- HIGH_TIME, out, CNT_WIDTH: last measured P high time in CLK_0 cycles.
- N_EDGES, out, 8: N rising edges counted in the last P period; saturates at 255.
- MEAS_VALID, out, 1: one-cycle strobe; PERIOD/HIGH_TIME/N_EDGES updated in this cycle.
- NO_SIGNAL, out, 1: level; high while in timeout, cleared by the next P rising edge.

## Operation

- **Input conditioning.** Each input passes through SYNC_STAGES flip-flops, then one history register. A rising or falling edge is detected as a mismatch between the last sync stage and the history register. There is no glitch filtering.
- **State IDLE** (entered on reset and on timeout):
  - Counters are held at 0.
  - On a P rising edge: go to MEASURE, set cnt = 1, n_cnt = 0, clear NO_SIGNAL.
- **State MEASURE:**
  - cnt increments by 1 each cycle and saturates at all-ones.
  - P falling edge: hi_lat <= cnt (high time = cycles from rising edge to falling edge).
  - N rising edge: n_cnt increments, saturating at 255.
  - P rising edge:
    - PERIOD <= cnt
    - HIGH_TIME <= hi_lat
    - N_EDGES <= n_cnt
    - MEAS_VALID = 1 for this cycle
    - then cnt = 1, n_cnt = 0 (or 1 if an N rising edge is detected in the same cycle), hi_lat = 0.
  - cnt reaches TIMEOUT_CYCLES with no P rising edge: go to IDLE, NO_SIGNAL <= 1, MEAS_VALID stays 0. The result registers keep their last values.
- **First period after reset or timeout** produces no MEAS_VALID. Two P rising edges are always required.
- **No P falling edge in a period** (impossible for a clean input; possible with glitches): HIGH_TIME reports 0.
- **Simultaneous events:**
  - P rising edge and timeout in the same cycle: the edge wins, the measurement is reported, and NO_SIGNAL stays 0.
  - N edge coincident with a P rising edge: counted toward the new period.
  - P rising and falling edges cannot coincide, because they come from one detector.
- **Arithmetic:** all counters are unsigned and saturating; none wraps.

## Timing

- **Reset values:**
  - PERIOD = 0, HIGH_TIME = 0, N_EDGES = 0
  - MEAS_VALID = 0, NO_SIGNAL = 0
  - state = IDLE, synchronizers and history registers = 0
- **Reset** is sampled only on a CLK_0 rising edge. Asserting it mid-period discards the partial measurement, and outputs return to their reset values on the next edge.
- **Detection latency:** a P level change first sampled at clock edge k is detected at edge k + SYNC_STAGES. MEAS_VALID and the new output values are visible after that edge, i.e. 2 cycles after sampling with default parameters.
- **Accuracy:** PERIOD and HIGH_TIME are exact in cycles for inputs synchronous to CLK_0. For asynchronous inputs each value is ±1 cycle.
- **MEAS_VALID** is never high in consecutive cycles. The minimum measurable period is 2 cycles.
- **Throughput:** one result per P period; there is no backpressure.

## Test plan

- **Basic square wave.** Reset, then drive P 10 high / 10 low for 5 periods with N low. Require: MEAS_VALID pulses 4 times, 20 cycles apart; PERIOD = 20, HIGH_TIME = 10, N_EDGES = 0; no MEAS_VALID before the second P rising edge.
- **Generator ratio.** Drive P with a period of 2^12 cycles and N at twice that frequency, phase-aligned, modelling the generator's adjacent counter bits. Require PERIOD = 4096, HIGH_TIME = 2048, N_EDGES = 2 on every strobe.
- **Timeout.** Set TIMEOUT_CYCLES = 100, run 3 periods of 20, then hold P low. Require NO_SIGNAL = 1 exactly 100 cycles after the last detected rising edge, with PERIOD still 20. A later restart needs two edges before the next MEAS_VALID; NO_SIGNAL clears on the first of them.
- **Reset mid-operation.** Pull RST_N low for 1 cycle in mid-period. Require all outputs 0 on the next edge and the first strobe only after two further P rising edges.
- **Saturation.** Toggle N 300 times within one P period. Require N_EDGES = 255. Also drive an N rising edge coincident with a P rising edge and require it to be counted in the following period.
